axi32_master_cell: RTL and testbench

//  Single-outstanding AXI4-Lite initiator. Converts one-shot commands from local logic

---
 rtl/axi32_master_cell_if.sv | 51 +++++
 rtl/axi32_master_cell.sv | 121 ++++++++++++
 tb/tb_axi32_master_cell.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi32_master_cell_if.sv
// axi32_master_cell_if: local command/response port plus AXI4-Lite master bus for axi32_master_cell.
interface axi32_master_cell_if #(
    parameter int datawidth = 32,
    parameter int addrwidth = 8
);
    logic                   cmd_valid_in;
    logic                   cmd_ready_out;
    logic                   cmd_write_in;
    logic [addrwidth-1:0]   cmd_addr_in;
    logic [datawidth-1:0]   cmd_wdata_in;
    logic [datawidth/8-1:0] cmd_wstrb_in;
    logic                   rsp_valid_out;
    logic [datawidth-1:0]   rsp_rdata_out;
    logic [1:0]             rsp_resp_out;
    logic                   rsp_timeout_out;
    logic [addrwidth-1:0]   m_axi_awaddr_out;
    logic                   m_axi_awvalid_out;
    logic                   m_axi_awready_in;
    logic [datawidth-1:0]   m_axi_wdata_out;
    logic [datawidth/8-1:0] m_axi_wstrb_out;
    logic                   m_axi_wvalid_out;
    logic                   m_axi_wready_in;
    logic [1:0]             m_axi_bresp_in;
    logic                   m_axi_bvalid_in;
    logic                   m_axi_bready_out;
    logic [addrwidth-1:0]   m_axi_araddr_out;
    logic                   m_axi_arvalid_out;
    logic                   m_axi_arready_in;
    logic [datawidth-1:0]   m_axi_rdata_in;
    logic [1:0]             m_axi_rresp_in;
    logic                   m_axi_rvalid_in;
    logic                   m_axi_rready_out;

    modport master (
        input  cmd_valid_in, cmd_write_in, cmd_addr_in, cmd_wdata_in, cmd_wstrb_in,
        output cmd_ready_out, rsp_valid_out, rsp_rdata_out, rsp_resp_out, rsp_timeout_out,
        output m_axi_awaddr_out, m_axi_awvalid_out, m_axi_wdata_out, m_axi_wstrb_out, m_axi_wvalid_out,
        output m_axi_bready_out, m_axi_araddr_out, m_axi_arvalid_out, m_axi_rready_out,
        input  m_axi_awready_in, m_axi_wready_in, m_axi_bresp_in, m_axi_bvalid_in,
        input  m_axi_arready_in, m_axi_rdata_in, m_axi_rresp_in, m_axi_rvalid_in
    );

    modport slave (
        output cmd_valid_in, cmd_write_in, cmd_addr_in, cmd_wdata_in, cmd_wstrb_in,
        input  cmd_ready_out, rsp_valid_out, rsp_rdata_out, rsp_resp_out, rsp_timeout_out,
        input  m_axi_awaddr_out, m_axi_awvalid_out, m_axi_wdata_out, m_axi_wstrb_out, m_axi_wvalid_out,
        input  m_axi_bready_out, m_axi_araddr_out, m_axi_arvalid_out, m_axi_rready_out,
        output m_axi_awready_in, m_axi_wready_in, m_axi_bresp_in, m_axi_bvalid_in,
        output m_axi_arready_in, m_axi_rdata_in, m_axi_rresp_in, m_axi_rvalid_in
    );
endinterface

// File: rtl/axi32_master_cell.sv
// axi32_master_cell: single-outstanding AXI4-Lite initiator, one local command -> one AXI transaction -> one response.
// Define AXI_MASTER_TIMEOUT_EN to add a watchdog that aborts a stalled transaction after timeout_cycles clocks.
module axi32_master_cell #(
    parameter int datawidth      = 32,
    parameter int addrwidth      = 8,
    parameter int timeout_cycles = 255
) (
    input logic                 m_axi_clk_in,
    input logic                 m_axi_reset_in,
    axi32_master_cell_if.master bus
);
    typedef enum logic [1:0] {IDLE, WR, RD, DONE} state_t;

    state_t state;
    logic   b_hs;
    logic   r_hs;

    if (timeout_cycles < 1 || timeout_cycles > 65535) begin : g_bad_timeout
        $error("axi32_master_cell: timeout_cycles must be 1..65535");
    end

    // A response is taken only once every request channel has handshaken or is handshaking now.
    assign b_hs = state == WR && bus.m_axi_bvalid_in && bus.m_axi_bready_out &&
                  (!bus.m_axi_awvalid_out || bus.m_axi_awready_in) &&
                  (!bus.m_axi_wvalid_out || bus.m_axi_wready_in);
    assign r_hs = state == RD && bus.m_axi_rvalid_in && bus.m_axi_rready_out &&
                  (!bus.m_axi_arvalid_out || bus.m_axi_arready_in);

`ifdef AXI_MASTER_TIMEOUT_EN
    localparam logic [15:0] limit = 16'(timeout_cycles - 1);
    logic [15:0] cnt;
    logic        timed_out;
    assign bus.rsp_timeout_out = timed_out;
`else
    assign bus.rsp_timeout_out = 1'b0;
`endif

    always_ff @(posedge m_axi_clk_in) begin
        if (m_axi_reset_in) begin
            state                 <= IDLE;
            bus.cmd_ready_out     <= 1'b0;
            bus.rsp_valid_out     <= 1'b0;
            bus.rsp_rdata_out     <= '0;
            bus.rsp_resp_out      <= 2'b00;
            bus.m_axi_awaddr_out  <= '0;
            bus.m_axi_awvalid_out <= 1'b0;
            bus.m_axi_wdata_out   <= '0;
            bus.m_axi_wstrb_out   <= '0;
            bus.m_axi_wvalid_out  <= 1'b0;
            bus.m_axi_bready_out  <= 1'b0;
            bus.m_axi_araddr_out  <= '0;
            bus.m_axi_arvalid_out <= 1'b0;
            bus.m_axi_rready_out  <= 1'b0;
`ifdef AXI_MASTER_TIMEOUT_EN
            cnt                   <= '0;
            timed_out             <= 1'b0;
`endif
        end else begin
            bus.rsp_valid_out <= 1'b0;
            case (state)
                IDLE: begin
                    bus.cmd_ready_out <= 1'b1;
                    if (bus.cmd_valid_in && bus.cmd_ready_out) begin
                        bus.cmd_ready_out     <= 1'b0;
                        state                 <= bus.cmd_write_in ? WR : RD;
                        bus.m_axi_awaddr_out  <= bus.cmd_write_in ? bus.cmd_addr_in : bus.m_axi_awaddr_out;
                        bus.m_axi_wdata_out   <= bus.cmd_write_in ? bus.cmd_wdata_in : bus.m_axi_wdata_out;
                        bus.m_axi_wstrb_out   <= bus.cmd_write_in ? bus.cmd_wstrb_in : bus.m_axi_wstrb_out;
                        bus.m_axi_araddr_out  <= bus.cmd_write_in ? bus.m_axi_araddr_out : bus.cmd_addr_in;
                        bus.m_axi_awvalid_out <= bus.cmd_write_in;
                        bus.m_axi_wvalid_out  <= bus.cmd_write_in;
                        bus.m_axi_bready_out  <= bus.cmd_write_in;
                        bus.m_axi_arvalid_out <= !bus.cmd_write_in;
                        bus.m_axi_rready_out  <= !bus.cmd_write_in;
                    end
                end
                WR: begin
                    if (bus.m_axi_awready_in) bus.m_axi_awvalid_out <= 1'b0;
                    if (bus.m_axi_wready_in) bus.m_axi_wvalid_out <= 1'b0;
                    if (b_hs) begin
                        bus.m_axi_bready_out <= 1'b0;
                        bus.rsp_resp_out     <= bus.m_axi_bresp_in;
                        bus.rsp_valid_out    <= 1'b1;
                        state                <= DONE;
                    end
                end
                RD: begin
                    if (bus.m_axi_arready_in) bus.m_axi_arvalid_out <= 1'b0;
                    if (r_hs) begin
                        bus.m_axi_rready_out <= 1'b0;
                        bus.rsp_rdata_out    <= bus.m_axi_rdata_in;
                        bus.rsp_resp_out     <= bus.m_axi_rresp_in;
                        bus.rsp_valid_out    <= 1'b1;
                        state                <= DONE;
                    end
                end
                DONE: begin
                    state             <= IDLE;
                    bus.cmd_ready_out <= 1'b1;
                end
                default: state <= IDLE;
            endcase
`ifdef AXI_MASTER_TIMEOUT_EN
            cnt       <= (state == WR || state == RD) ? cnt + 16'd1 : 16'd0;
            timed_out <= (state == DONE) ? 1'b0 : timed_out;
            // Abort overrides the channel updates above; a handshake in the same cycle still wins.
            if ((state == WR || state == RD) && !b_hs && !r_hs && cnt == limit) begin
                bus.m_axi_awvalid_out <= 1'b0;
                bus.m_axi_wvalid_out  <= 1'b0;
                bus.m_axi_bready_out  <= 1'b0;
                bus.m_axi_arvalid_out <= 1'b0;
                bus.m_axi_rready_out  <= 1'b0;
                bus.rsp_resp_out      <= 2'b10;
                bus.rsp_valid_out     <= 1'b1;
                timed_out             <= 1'b1;
                state                 <= DONE;
            end
`endif
        end
    end
endmodule

// File: tb/tb_axi32_master_cell.sv
// tb_axi32_master_cell: directed checks of axi32_master_cell against a small AXI4-Lite slave model.
// Build with AXI_MASTER_TIMEOUT_EN defined to exercise the watchdog (timeout_cycles = 16).
module tb_axi32_master_cell;
    logic clk = 1'b0;
    logic rst = 1'b1;

    axi32_master_cell_if #(.datawidth(32), .addrwidth(8)) bus ();

    axi32_master_cell #(.datawidth(32), .addrwidth(8), .timeout_cycles(16)) dut (
        .m_axi_clk_in  (clk),
        .m_axi_reset_in(rst),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // slave model configuration
    int          w_lat    = 0;
    int          r_wait   = 0;
    bit          aw_never = 1'b0;
    logic [1:0]  r_resp_v = 2'b00;
    logic [31:0] mem [4]  = '{32'h5446_0000, 32'h0, 32'h0, 32'h0};

    logic        aw_done, w_done, ar_done;
    int          w_cnt, r_cnt;
    logic [7:0]  aw_a, ar_a, wa;
    logic [31:0] w_d, wd;
    logic [3:0]  w_s, ws;

    assign wa = aw_done ? aw_a : bus.m_axi_awaddr_out;
    assign wd = w_done ? w_d : bus.m_axi_wdata_out;
    assign ws = w_done ? w_s : bus.m_axi_wstrb_out;

    always @(negedge clk) begin
        bus.m_axi_awready_in = bus.m_axi_awvalid_out && !aw_never;
        bus.m_axi_wready_in  = bus.m_axi_wvalid_out &&
                               (w_lat == 0 ? (aw_done || bus.m_axi_awready_in) : (aw_done && w_cnt >= w_lat));
        bus.m_axi_bvalid_in  = bus.m_axi_bready_out && (aw_done || bus.m_axi_awready_in) &&
                               (w_done || bus.m_axi_wready_in);
        bus.m_axi_bresp_in   = 2'b00;
        bus.m_axi_arready_in = bus.m_axi_arvalid_out;
        bus.m_axi_rvalid_in  = ar_done && r_cnt >= r_wait;
        bus.m_axi_rdata_in   = bus.m_axi_rvalid_in ? mem[ar_a[3:2]] : 32'h0;
        bus.m_axi_rresp_in   = bus.m_axi_rvalid_in ? r_resp_v : 2'b00;
    end

    always @(posedge clk) begin
        if (rst) begin
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            ar_done <= 1'b0;
            w_cnt   <= 0;
            r_cnt   <= 0;
        end else begin
            if (bus.m_axi_awvalid_out && bus.m_axi_awready_in) begin
                aw_done <= 1'b1;
                aw_a    <= bus.m_axi_awaddr_out;
                w_cnt   <= 1;
            end else if (aw_done) w_cnt <= w_cnt + 1;
            if (bus.m_axi_wvalid_out && bus.m_axi_wready_in) begin
                w_done <= 1'b1;
                w_d    <= bus.m_axi_wdata_out;
                w_s    <= bus.m_axi_wstrb_out;
            end
            if (bus.m_axi_bvalid_in && bus.m_axi_bready_out) begin
                for (int b = 0; b < 4; b++) if (ws[b]) mem[wa[3:2]][8*b +: 8] <= wd[8*b +: 8];
                aw_done <= 1'b0;
                w_done  <= 1'b0;
            end
            if (bus.m_axi_arvalid_out && bus.m_axi_arready_in) begin
                ar_done <= 1'b1;
                ar_a    <= bus.m_axi_araddr_out;
                r_cnt   <= 0;
            end else if (ar_done) r_cnt <= r_cnt + 1;
            if (bus.m_axi_rvalid_in && bus.m_axi_rready_out) ar_done <= 1'b0;
        end
    end

    // event monitor: cycle stamps, pulse count, channel stability
    int          cyc = 0, acc_cyc = 0, aw_cyc = 0, w_cyc = 0, rsp_cnt = 0, wonly = 0, viol = 0;
    bit          p_rst, p_awv, p_awhs, p_wv, p_whs, p_arv, p_arhs;
    logic [7:0]  p_awaddr, p_araddr;
    logic [31:0] p_wdata;
    logic [3:0]  p_wstrb;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.cmd_valid_in && bus.cmd_ready_out) acc_cyc <= cyc;
        if (bus.rsp_valid_out) rsp_cnt <= rsp_cnt + 1;
        if (bus.m_axi_awvalid_out && bus.m_axi_awready_in) aw_cyc <= cyc;
        if (bus.m_axi_wvalid_out && bus.m_axi_wready_in) w_cyc <= cyc;
        if (bus.m_axi_wvalid_out && !bus.m_axi_awvalid_out) wonly <= wonly + 1;
        if (!rst && !p_rst) begin
            if (p_awv && !p_awhs && (!bus.m_axi_awvalid_out || bus.m_axi_awaddr_out != p_awaddr)) viol <= viol + 1;
            if (p_wv && !p_whs && (!bus.m_axi_wvalid_out || bus.m_axi_wdata_out != p_wdata ||
                                   bus.m_axi_wstrb_out != p_wstrb)) viol <= viol + 1;
            if (p_arv && !p_arhs && (!bus.m_axi_arvalid_out || bus.m_axi_araddr_out != p_araddr)) viol <= viol + 1;
        end
        p_rst    <= rst;
        p_awv    <= bus.m_axi_awvalid_out;
        p_awhs   <= bus.m_axi_awvalid_out && bus.m_axi_awready_in;
        p_awaddr <= bus.m_axi_awaddr_out;
        p_wv     <= bus.m_axi_wvalid_out;
        p_whs    <= bus.m_axi_wvalid_out && bus.m_axi_wready_in;
        p_wdata  <= bus.m_axi_wdata_out;
        p_wstrb  <= bus.m_axi_wstrb_out;
        p_arv    <= bus.m_axi_arvalid_out;
        p_arhs   <= bus.m_axi_arvalid_out && bus.m_axi_arready_in;
        p_araddr <= bus.m_axi_araddr_out;
    end

    function automatic logic [4:0] valids();
        return {bus.m_axi_awvalid_out, bus.m_axi_wvalid_out, bus.m_axi_bready_out,
                bus.m_axi_arvalid_out, bus.m_axi_rready_out};
    endfunction

    task automatic issue(input string tag, input logic wr, input logic [7:0] a, input logic [31:0] d,
                         input logic [3:0] s);
        for (int i = 0; i < 50 && !bus.cmd_ready_out; i++) @(negedge clk);
        check({tag, "_cmd_ready"}, 64'(bus.cmd_ready_out), 64'd1);
        bus.cmd_valid_in = 1'b1;
        bus.cmd_write_in = wr;
        bus.cmd_addr_in  = a;
        bus.cmd_wdata_in = d;
        bus.cmd_wstrb_in = s;
        @(posedge clk);
        #1 bus.cmd_valid_in = 1'b0;
    endtask

    task automatic expect_rsp(input string tag, input int lat, input logic [1:0] resp,
                              input logic [31:0] rdata, input logic tmo);
        for (int i = 0; i < 60 && !bus.rsp_valid_out; i++) @(negedge clk);
        check({tag, "_pulse"}, 64'(bus.rsp_valid_out), 64'd1);
        check({tag, "_latency"}, 64'(cyc - acc_cyc), 64'(lat));
        check({tag, "_resp"}, 64'(bus.rsp_resp_out), 64'(resp));
        check({tag, "_rdata"}, 64'(bus.rsp_rdata_out), 64'(rdata));
        check({tag, "_timeout"}, 64'(bus.rsp_timeout_out), 64'(tmo));
        check({tag, "_valids_idle"}, 64'(valids()), 64'd0);
        check({tag, "_ready_low"}, 64'(bus.cmd_ready_out), 64'd0);
        @(negedge clk);
        check({tag, "_single_then_ready"}, 64'({bus.rsp_valid_out, bus.cmd_ready_out}), 64'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int rc0;
        bus.cmd_valid_in = 1'b0;
        bus.cmd_write_in = 1'b0;
        bus.cmd_addr_in  = 8'h0;
        bus.cmd_wdata_in = 32'h0;
        bus.cmd_wstrb_in = 4'h0;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 64'(bus.cmd_ready_out), 64'd0);
        check("rst_valids", 64'(valids()), 64'd0);
        check("rst_rsp", 64'({bus.rsp_valid_out, bus.rsp_resp_out, bus.rsp_timeout_out}), 64'd0);
        check("rst_rdata", 64'(bus.rsp_rdata_out), 64'd0);
        check("rst_addr_data", 64'({bus.m_axi_awaddr_out, bus.m_axi_araddr_out, bus.m_axi_wstrb_out,
                                    bus.m_axi_wdata_out}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 64'(bus.cmd_ready_out), 64'd1);

        // 1: write, slave ready at once -> AW/W together, response two cycles after accept
        issue("t1", 1'b1, 8'h04, 32'h0000_0003, 4'hF);
        expect_rsp("t1", 2, 2'b00, 32'h0, 1'b0);
        check("t1_aw_at_n1", 64'(aw_cyc - acc_cyc), 64'd1);
        check("t1_aw_w_same", 64'(w_cyc - aw_cyc), 64'd0);
        check("t1_mem", 64'(mem[1]), 64'h0000_0003);

        // 2: wready three cycles after awready, partial strobes
        w_lat = 3;
        rc0   = wonly;
        issue("t2", 1'b1, 8'h08, 32'hA5A5_1234, 4'h3);
        expect_rsp("t2", 5, 2'b00, 32'h0, 1'b0);
        check("t2_w_after_aw", 64'(w_cyc - aw_cyc), 64'd3);
        check("t2_w_alone_cycles", 64'(wonly - rc0), 64'd3);
        check("t2_mem", 64'(mem[2]), 64'h0000_1234);
        w_lat = 0;

        // 3: read with two wait states, then a write must not disturb rsp_rdata
        r_wait = 2;
        issue("t3r", 1'b0, 8'h00, 32'h0, 4'h0);
        expect_rsp("t3r", 5, 2'b00, 32'h5446_0000, 1'b0);
        r_wait = 0;
        issue("t3w", 1'b1, 8'h0C, 32'h1122_3344, 4'hF);
        expect_rsp("t3w", 2, 2'b00, 32'h5446_0000, 1'b0);
        check("t3_mem", 64'(mem[3]), 64'h1122_3344);

        // 4: read with RRESP error
        r_resp_v = 2'b11;
        issue("t4", 1'b0, 8'h0C, 32'h0, 4'h0);
        expect_rsp("t4", 3, 2'b11, 32'h1122_3344, 1'b0);
        r_resp_v = 2'b00;

        // 6: reset while wvalid pending aborts silently; next command completes
        w_lat = 50;
        issue("t6", 1'b1, 8'h04, 32'hFFFF_FFFF, 4'hF);
        repeat (3) @(negedge clk);
        check("t6_w_pending", 64'({bus.m_axi_awvalid_out, bus.m_axi_wvalid_out}), 64'b01);
        rc0 = rsp_cnt;
        rst = 1'b1;
        @(negedge clk);
        check("t6_valids_cleared", 64'(valids()), 64'd0);
        check("t6_ready_in_rst", 64'(bus.cmd_ready_out), 64'd0);
        rst   = 1'b0;
        w_lat = 0;
        @(negedge clk);
        check("t6_no_rsp", 64'(rsp_cnt - rc0), 64'd0);
        check("t6_mem_untouched", 64'(mem[1]), 64'h0000_0003);
        issue("t6b", 1'b0, 8'h04, 32'h0, 4'h0);
        expect_rsp("t6b", 3, 2'b00, 32'h0000_0003, 1'b0);
        check("stability_violations", 64'(viol), 64'd0);
        check("rsp_pulses", 64'(rsp_cnt), 64'd6);

        // 5: slave never accepts AW
        aw_never = 1'b1;
        issue("t5", 1'b1, 8'h08, 32'hDEAD_BEEF, 4'hF);
`ifdef AXI_MASTER_TIMEOUT_EN
        expect_rsp("t5", 17, 2'b10, 32'h0000_0003, 1'b1);
        check("t5_rsp_pulses", 64'(rsp_cnt), 64'd7);
        check("t5_mem_untouched", 64'(mem[2]), 64'h0000_1234);
`else
        rc0 = rsp_cnt;
        repeat (1000) @(negedge clk);
        check("t5_no_rsp", 64'(rsp_cnt - rc0), 64'd0);
        check("t5_still_waiting", 64'({bus.m_axi_awvalid_out, bus.m_axi_wvalid_out, bus.m_axi_bready_out}), 64'b111);
        check("t5_timeout_flag", 64'(bus.rsp_timeout_out), 64'd0);
`endif
        aw_never = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
